// File: rtl/simon_share_ctrl.sv
// Phase sequencer (IDLE/LOAD/ROUND/DRAIN) for one share of the bit-serial SIMON128 datapath.
// Optional abort input is enabled by defining SIMON_CTRL_ABORT_EN.
module simon_share_ctrl #(
  parameter int WORD   = 64,
  parameter int ROUNDS = 68,
  localparam int BW    = $clog2(WORD),
  localparam int RW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef SIMON_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          out_valid,
  output logic          key_en,
  output logic          shifter_enable1,
  output logic          shifter_enable2,
  output logic          s1,
  output logic          s2,
  output logic [1:0]    s3,
  output logic [RW-1:0] round_idx,
  output logic [BW-1:0] bit_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state_reg;
  logic [BW-1:0] bit_cnt_reg;
  logic [RW-1:0] rnd_cnt_reg;
  logic          half_reg;
  logic          done_reg;

  logic bit_last;
  logic rnd_last;
  logic abort_hit;

  assign bit_last = (bit_cnt_reg == BW'(WORD - 1));
  assign rnd_last = (rnd_cnt_reg == RW'(ROUNDS - 1));

`ifdef SIMON_CTRL_ABORT_EN
  assign abort_hit = abort && (state_reg != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      rnd_cnt_reg <= '0;
      half_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort_hit) begin
        state_reg   <= IDLE;
        bit_cnt_reg <= '0;
        rnd_cnt_reg <= '0;
        half_reg    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg   <= LOAD;
              bit_cnt_reg <= '0;
              rnd_cnt_reg <= '0;
              half_reg    <= 1'b0;
            end
          end
          LOAD: begin
            // bit_cnt wraps naturally because WORD is a power of two
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_last) begin
              half_reg <= ~half_reg;
              if (half_reg) begin
                state_reg   <= ROUND;
                rnd_cnt_reg <= '0;
              end
            end
          end
          ROUND: begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_last) begin
              if (rnd_last) state_reg <= DRAIN;
              else          rnd_cnt_reg <= rnd_cnt_reg + 1'b1;
            end
          end
          DRAIN: begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_last) begin
              state_reg   <= IDLE;
              rnd_cnt_reg <= '0;
              done_reg    <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Outputs decode from state and counters only, never from start.
  always_comb begin
    busy            = (state_reg != IDLE);
    done            = done_reg;
    out_valid       = 1'b0;
    key_en          = 1'b0;
    shifter_enable1 = 1'b0;
    shifter_enable2 = 1'b0;
    s1              = 1'b0;
    s2              = 1'b0;
    s3              = 2'd3;
    round_idx       = rnd_cnt_reg;
    bit_idx         = bit_cnt_reg;
    case (state_reg)
      LOAD: begin
        shifter_enable1 = 1'b1;
        shifter_enable2 = 1'b1;
        s1              = 1'b1;
        s3              = 2'd0;
      end
      ROUND: begin
        shifter_enable1 = 1'b1;
        shifter_enable2 = 1'b1;
        key_en          = 1'b1;
        s3              = 2'd2;
        // Low 8 bits cover the rotation wrap; top 8 bits feed shifter1 from the other path
        s2              = (bit_cnt_reg < BW'(8));
        s1              = !(bit_cnt_reg >= BW'(WORD - 8));
        out_valid       = rnd_last;
      end
      DRAIN: begin
        shifter_enable1 = 1'b1;
        shifter_enable2 = 1'b1;
        s1              = 1'b1;
        s3              = 2'd1;
        out_valid       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_simon_share_ctrl.sv
// Randomized directed bench for simon_share_ctrl checked cycle by cycle against a
// phase-timeline model (time since start -> expected outputs).
module tb_simon_share_ctrl;
  localparam int W     = 64;
  localparam int R     = 68;
  localparam int TOTAL = 2 * W + R * W + W;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, out_valid, key_en, en1, en2, s1, s2;
  logic [1:0] s3;
  logic [6:0] round_idx;
  logic [5:0] bit_idx;

  simon_share_ctrl #(.WORD(W), .ROUNDS(R)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SIMON_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .out_valid(out_valid), .key_en(key_en),
    .shifter_enable1(en1), .shifter_enable2(en2), .s1(s1), .s2(s2), .s3(s3),
    .round_idx(round_idx), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  int   t = -1;      // model: cycles since first LOAD cycle, -1 when idle
  logic exp_d = 1'b0;
  int   n_cmp = 0, n_fail = 0, dut_done = 0, mdl_done = 0, cyc = 0;

  logic [22:0] obs;
  assign obs = {busy, done, out_valid, key_en, en1, en2, s1, s2, s3, round_idx, bit_idx};

  function automatic logic [22:0] exp_outs(int tt, logic d);
    int u, b, r;
    logic bz, ov, k, e, s1e, s2e;
    logic [1:0] s3e;
    bz = 0; ov = 0; k = 0; e = 0; s1e = 0; s2e = 0; s3e = 2'd3; r = 0; b = 0;
    if (tt >= 0 && tt < 2 * W) begin
      bz = 1; e = 1; s1e = 1; s3e = 2'd0; b = tt % W;
    end else if (tt >= 2 * W && tt < 2 * W + R * W) begin
      u = tt - 2 * W; r = u / W; b = u % W;
      bz = 1; e = 1; k = 1; s3e = 2'd2;
      s2e = (b < 8); s1e = (b < W - 8); ov = (r == R - 1);
    end else if (tt >= 2 * W + R * W) begin
      b = tt - 2 * W - R * W; r = R - 1;
      bz = 1; e = 1; s1e = 1; s3e = 2'd1; ov = 1;
    end
    return {bz, d, ov, k, e, e, s1e, s2e, s3e, 7'(r), 6'(b)};
  endfunction

  task automatic chk(input string tag, input logic [22:0] o, input logic [22:0] x);
    n_cmp++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: cycle %0d observed %h expected %h", tag, cyc, o, x);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at that edge, then check.
  task automatic step();
    @(posedge clk);
    cyc++;
    exp_d = 1'b0;
    if (!rst_n) t = -1;
    else if (abort && t >= 0) t = -1;
    else if (t < 0) begin
      if (start) t = 0;
    end else if (t == TOTAL - 1) begin
      t = -1; exp_d = 1'b1; mdl_done++;
    end else t++;
    #1;
    chk("outs", obs, exp_outs(t, exp_d));
    if (done === 1'b1) begin
      dut_done++;
      $display("encryption %0d done at cycle %0d", dut_done, cyc);
    end
  endtask

  initial begin
    int k;
    #1;
    chk("reset_hold", obs, exp_outs(-1, 1'b0));
    repeat (3) step();
    rst_n = 1'b1;

    // Single encryption with stray start pulses while busy
    repeat ($urandom_range(1, 5)) step();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < TOTAL + 5; i++) begin
      start = ($urandom_range(0, 63) == 0);
      if (t < 0 || t == TOTAL - 1) start = 1'b0;
      step();
    end
    start = 1'b0;

    // Start held high: back-to-back encryptions
    start = 1'b1;
    repeat (2 * TOTAL + 4) step();
    start = 1'b0;
    repeat (5) step();

    // Asynchronous reset in the middle of ROUND
    start = 1'b1; step(); start = 1'b0;
    k = $urandom_range(900, 1100);
    repeat (k) step();
    #2 rst_n = 1'b0;
    #1 chk("async_rst", obs, exp_outs(-1, 1'b0));
    repeat (3) step();
    rst_n = 1'b1;
    repeat (200) step();

`ifdef SIMON_CTRL_ABORT_EN
    // Abort at round 10, bit 30, then a full fresh run
    start = 1'b1; step(); start = 1'b0;
    repeat (2 * W + 10 * W + 30) step();
    abort = 1'b1; step(); abort = 1'b0;
    repeat (10) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (TOTAL + 3) step();
`endif

    n_cmp++;
    assert (dut_done == mdl_done) else begin
      n_fail++;
      $error("FAIL done_count: observed %0d expected %0d", dut_done, mdl_done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/simon_share_ctrl.md
# simon_share_ctrl

Sequencing controller for one share of the bit-serial SIMON128 datapath. It drives the shifter enables and the path selects `s1`, `s2` and `s3[1:0]`, and gates the round-key stream. It runs each encryption through four phases: load the plaintext, run the rounds bit by bit, drain the ciphertext, then report done. It sits directly upstream of the share datapath, and one instance serves each share.

## Interface
Parameters:
- `WORD`, 64: word width in bits; the bit counter is clog2(`WORD`) wide.
- `ROUNDS`, 68: number of cipher rounds; the round counter is clog2(`ROUNDS`) wide.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request to begin an encryption; sampled only in IDLE.
- `busy`  out  1  high from the first LOAD cycle to the last DRAIN cycle.
- `done`  out  1  single-cycle pulse after DRAIN completes.
- `out_valid`  out  1  high when `cipher_out` carries a ciphertext bit (final round and DRAIN).
- `key_en`  out  1  advance request to the key-schedule stage; high in all ROUND cycles.
- `shifter_enable1`  out  1  enable for the shifter1 and FIFO chains.
- `shifter_enable2`  out  1  enable for shifter2.
- `s1`  out  1  shifter1 input select.
- `s2`  out  1  FIFO/LUT chain swap.
- `s3`  out  2  ff63 input select (0 = data, 1 = recirculate, 2 = round function, 3 = hold).
- `round_idx`  out  clog2(`ROUNDS`)  current round number.
- `bit_idx`  out  clog2(`WORD`)  current bit position within the word.

## Operation
The FSM has four states: IDLE, LOAD, ROUND and DRAIN. Two counters support it: `bit_cnt`, which runs 0..`WORD`-1, and `rnd_cnt`, which runs 0..`ROUNDS`-1.

- **IDLE:** both enables 0, `s1`=0, `s2`=0, `s3`=3, `key_en`=0. When `start`=1, the FSM clears both counters and moves to LOAD.
- **LOAD:** lasts 2·`WORD` cycles.
  - `s3`=0, `s2`=0, `s1`=1, both enables 1.
  - `bit_cnt` wraps at `WORD`-1, and a 1-bit half flag records the wrap.
  - At the end of the second half, the FSM moves to ROUND with both counters at 0.
- **ROUND:** `WORD` cycles per round.
  - `s3`=2, `key_en`=1, both enables 1.
  - `s2`=1 when `bit_cnt`<8, otherwise 0. This covers the rotation wrap bits.
  - `s1`=0 when `bit_cnt`≥`WORD`-8, otherwise 1.
  - When `bit_cnt`=`WORD`-1: if `rnd_cnt`=`ROUNDS`-1, the FSM moves to DRAIN; otherwise `rnd_cnt` increments.
- **DRAIN:** `WORD` cycles.
  - `s3`=1, `s2`=0, `s1`=1, both enables 1, `key_en`=0, `out_valid`=1.
  - After the last cycle the FSM returns to IDLE and pulses `done`.
- **`out_valid`:** also high throughout ROUND while `rnd_cnt`=`ROUNDS`-1.
- **Output timing:** all outputs are registered or decoded from state and counters only. No output has a combinational path from `start`.
- **`round_idx` / `bit_idx`:** mirror `rnd_cnt` / `bit_cnt` in every state. Both read 0 in IDLE.

## Timing
- **Reset values:** state IDLE, counters 0, `busy`=0, `done`=0, `out_valid`=0, `key_en`=0, both enables 0, `s1`=0, `s2`=0, `s3`=3.
- **Start latency:** if `start` is sampled high at edge k, the first LOAD cycle follows edge k.
- **Phase windows:**
  - LOAD occupies 128 cycles.
  - ROUND occupies 68·64 = 4352 cycles.
  - DRAIN occupies 64 cycles.
  - `done` is high in cycle 4545 counted from edge k, for one cycle only.
  - The next `start` is accepted in that same `done` cycle, since the FSM is back in IDLE.
- **Start while not idle:** ignored while `busy`=1, with no queuing.
- **Start held high:** a new encryption begins immediately after `done`.
- **Counter wrap:** `bit_cnt` wrap and the state change happen on the same edge. There is no idle bubble between phases or between rounds.
- **Reset mid-operation:** outputs return to reset values immediately (asynchronously). The aborted encryption produces no `done`.
- **Configuration limits:** `WORD` must be a power of two ≥16; `ROUNDS` must be ≥1. `ROUNDS`=1 makes the only round the final round (`out_valid` is high throughout it).

## Configuration
- **`SIMON_CTRL_ABORT_EN` defined:** adds input port `abort` (1 bit).
  - `abort`=1 in any non-IDLE state returns the FSM to IDLE at the next edge.
  - Counters clear, all outputs take their IDLE values, and no `done` is pulsed.
  - `abort` takes priority over phase transitions.
- **Not defined:** there is no `abort` port, and the FSM always completes once started.

## Test plan
- **Reset:** hold `rst_n`=0, then assert it low again mid-ROUND (around cycle 1000) → all outputs immediately at reset values; `done` never pulses.
- **Nominal run (`WORD`=64, `ROUNDS`=68):** pulse `start` → `busy` rises the next cycle; check the counts:
  - 128 cycles with `s3`=0;
  - 4352 cycles with `s3`=2 and `key_en`=1;
  - 64 cycles with `s3`=1;
  - `done` is a one-cycle pulse at cycle 4545.
- **Select pattern:** in ROUND with `bit_cnt`=0..7 → `s2`=1, `s1`=1; with `bit_cnt`=56..63 → `s2`=0, `s1`=0; with `bit_cnt`=8..55 → `s2`=0, `s1`=1.
- **`out_valid`:** high for exactly 128 cycles per encryption, beginning at round 67, bit 0.
- **Start handling:** `start` pulsed mid-LOAD → ignored, single `done`; `start` held high → second encryption's LOAD begins the cycle after `done`.
- **Abort (with `SIMON_CTRL_ABORT_EN`):** `abort`=1 at round 10, bit 30 → IDLE next cycle, `round_idx`=0, no `done`; a fresh `start` afterwards runs a full 4545-cycle encryption.
